// File: rtl/axi_request_originator_if.sv
// Bus bundle for axi_request_originator: AXI4-Lite slave side plus the
// request/response stream pair. The block uses the slave view, its environment the master view.
interface axi_request_originator_if;
  logic [31:0]  S_AXI_AWADDR;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [31:0]  S_AXI_ARADDR;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [71:0]  AXIS_OUT_TDATA;
  logic         AXIS_OUT_TVALID;
  logic         AXIS_OUT_TREADY;
  logic [255:0] AXIS_IN_TDATA;
  logic         AXIS_IN_TVALID;
  logic         AXIS_IN_TREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output AXIS_OUT_TDATA, AXIS_OUT_TVALID, input AXIS_OUT_TREADY,
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, output AXIS_IN_TREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WVALID, S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  AXIS_OUT_TDATA, AXIS_OUT_TVALID, output AXIS_OUT_TREADY,
    output AXIS_IN_TDATA, AXIS_IN_TVALID, input AXIS_IN_TREADY
  );
endinterface

// File: rtl/axi_request_originator.sv
// Converts single AXI4-Lite transactions into one 72-bit stream request each and
// returns the matching stream response on B or R. One transaction in flight at a time.
module axi_request_originator (
  input logic                      clk,
  input logic                      resetn,
  axi_request_originator_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSendReq, StWaitRsp, StWriteRsp, StReadRsp} state_e;

  state_e      state_q, state_d;
  logic        aw_captured_q, w_captured_q, prefer_read_q;
  logic [31:0] addr_q, data_q, rdata_q;
  logic        mode_q;
  logic [1:0]  resp_q;

  logic ar_grant;
  logic aw_ready, w_ready, ar_ready, out_valid, in_ready, b_valid, r_valid;
  logic aw_fire, w_fire, ar_fire, req_fire, rsp_fire, b_fire, r_fire;
  logic unused_in;

  // Read wins only with no write half held and either read priority or no write pending
  always_comb begin
    ar_grant = !aw_captured_q && !w_captured_q && bus.S_AXI_ARVALID &&
               (prefer_read_q || (!bus.S_AXI_AWVALID && !bus.S_AXI_WVALID));
  end

  assign aw_fire  = bus.S_AXI_AWVALID && aw_ready;
  assign w_fire   = bus.S_AXI_WVALID && w_ready;
  assign ar_fire  = bus.S_AXI_ARVALID && ar_ready;
  assign req_fire = out_valid && bus.AXIS_OUT_TREADY;
  assign rsp_fire = bus.AXIS_IN_TVALID && in_ready;
  assign b_fire   = b_valid && bus.S_AXI_BREADY;
  assign r_fire   = r_valid && bus.S_AXI_RREADY;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ar_fire) begin
          state_d = StSendReq;
        end else if ((aw_captured_q || aw_fire) && (w_captured_q || w_fire)) begin
          state_d = StSendReq;
        end
      end
      StSendReq:  if (req_fire) state_d = StWaitRsp;
      StWaitRsp:  if (rsp_fire) state_d = mode_q ? StReadRsp : StWriteRsp;
      StWriteRsp: if (b_fire) state_d = StIdle;
      StReadRsp:  if (r_fire) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Handshake outputs; everything held low while reset is asserted
  always_comb begin
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    ar_ready  = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    b_valid   = 1'b0;
    r_valid   = 1'b0;
    if (resetn) begin
      unique case (state_q)
        StIdle: begin
          ar_ready = ar_grant;
          aw_ready = !aw_captured_q && !ar_grant;
          w_ready  = !w_captured_q && !ar_grant;
        end
        StSendReq:  out_valid = 1'b1;
        StWaitRsp:  in_ready  = 1'b1;
        StWriteRsp: b_valid   = 1'b1;
        StReadRsp:  r_valid   = 1'b1;
        default: ;
      endcase
    end
  end

  // Capture flags persist until the write's B handshake; priority flips per completion
  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_captured_q <= 1'b0;
      w_captured_q  <= 1'b0;
      prefer_read_q <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_captured_q <= 1'b1;
      end else if (b_fire) begin
        aw_captured_q <= 1'b0;
      end
      if (w_fire) begin
        w_captured_q <= 1'b1;
      end else if (b_fire) begin
        w_captured_q <= 1'b0;
      end
      if (b_fire || r_fire) begin
        prefer_read_q <= !prefer_read_q;
      end
    end
  end

  // Transaction payload registers (not reset)
  always_ff @(posedge clk) begin
    if (ar_fire) begin
      addr_q <= bus.S_AXI_ARADDR;
      data_q <= '0;
      mode_q <= 1'b1;
    end
    if (aw_fire) begin
      addr_q <= bus.S_AXI_AWADDR;
      mode_q <= 1'b0;
    end
    if (w_fire) begin
      data_q <= bus.S_AXI_WDATA;
    end
    if (rsp_fire) begin
      resp_q <= bus.AXIS_IN_TDATA[65:64];
      if (mode_q) begin
        rdata_q <= bus.AXIS_IN_TDATA[63:32];
      end
    end
  end

  assign bus.S_AXI_AWREADY   = aw_ready;
  assign bus.S_AXI_WREADY    = w_ready;
  assign bus.S_AXI_ARREADY   = ar_ready;
  assign bus.S_AXI_BVALID    = b_valid;
  assign bus.S_AXI_BRESP     = resp_q;
  assign bus.S_AXI_RVALID    = r_valid;
  assign bus.S_AXI_RRESP     = resp_q;
  assign bus.S_AXI_RDATA     = rdata_q;
  assign bus.AXIS_OUT_TVALID = out_valid;
  assign bus.AXIS_OUT_TDATA  = {7'd0, mode_q, data_q, addr_q};
  assign bus.AXIS_IN_TREADY  = in_ready;

  // Response address and upper bits carry nothing the block needs
  assign unused_in = ^{bus.AXIS_IN_TDATA[255:66], bus.AXIS_IN_TDATA[31:0]};

endmodule
